// File: rtl/game_flow_pkg.sv
// Shared types and width helpers for the game-flow sequencer.
package game_flow_pkg;

    typedef enum logic [2:0] {
        INTRO     = 3'd0,
        START     = 3'd1,
        PLAY      = 3'd2,
        LEVEL_UP  = 3'd3,
        DYING     = 3'd4,
        REPLAY    = 3'd5,
        GAME_OVER = 3'd6,
        PAUSE     = 3'd7
    } state_e;

    function automatic int unsigned lives_width(input int unsigned lives);
        return $clog2(lives + 1);
    endfunction

    function automatic int unsigned level_width(input int unsigned levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

    function automatic int unsigned max_ticks(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_tick_timer.sv
// Frame-tick hold timer: counts tick_i pulses and flags the terminal tick.
module tick_timer #(
    parameter int unsigned MAX = 120,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clear_i,
    input  logic         tick_i,
    input  logic [W-1:0] term_i,
    output logic         expire_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = tick_i && (cnt_q == term_i);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: intro, start, play, level-up, death hold, game-over hold.
// Optional PAUSE state enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl
    import game_flow_pkg::*;
#(
    parameter int unsigned LIVES          = 3,
    parameter int unsigned LEVELS         = 4,
    parameter int unsigned DEATH_TICKS    = 60,
    parameter int unsigned GAMEOVER_TICKS = 120,
    localparam int unsigned LW = lives_width(LIVES),
    localparam int unsigned VW = level_width(LEVELS)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Execute,
    input  logic          finish,
    input  logic          fail,
    input  logic          frame_tick,
    input  logic          pause_btn,
    output logic          isIntro,
    output logic          restart,
    output logic          replay,
    output logic          level_start,
    output logic          dying,
    output logic          game_over,
    output logic          won,
    output logic          paused,
    output logic [LW-1:0] lives,
    output logic [VW-1:0] level
);

    localparam int unsigned TMAX = max_ticks(DEATH_TICKS, GAMEOVER_TICKS);
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_e        state_q, state_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [VW-1:0] level_q, level_d;
    logic          won_q, won_d;

    logic          timer_clear_c;
    logic          timer_tick_c;
    logic [TW-1:0] timer_term_c;
    logic          timer_expire_c;

    // Timer only runs in the two hold states and restarts on every state change.
    assign timer_clear_c = (state_d != state_q);
    assign timer_tick_c  = frame_tick && ((state_q == DYING) || (state_q == GAME_OVER));
    assign timer_term_c  = (state_q == DYING) ? TW'(DEATH_TICKS - 1) : TW'(GAMEOVER_TICKS - 1);

    tick_timer #(
        .MAX (TMAX),
        .W   (TW)
    ) u_tick_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear_i  (timer_clear_c),
        .tick_i   (timer_tick_c),
        .term_i   (timer_term_c),
        .expire_c (timer_expire_c)
    );

`ifndef GAME_PAUSE_EN
    logic unused_pause_c;
    assign unused_pause_c = pause_btn;
`endif

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        won_d   = won_q;
        case (state_q)
            INTRO: begin
                if (Execute) state_d = START;
            end
            START: begin
                lives_d = LW'(LIVES);
                level_d = '0;
                won_d   = 1'b0;
                state_d = PLAY;
            end
            PLAY: begin
                // finish outranks fail, which outranks pause
                if (finish) begin
                    if (level_q == VW'(LEVELS - 1)) begin
                        state_d = GAME_OVER;
                        won_d   = 1'b1;
                    end else begin
                        state_d = LEVEL_UP;
                    end
                end else if (fail) begin
                    state_d = DYING;
                    lives_d = lives_q - LW'(1);
                end
`ifdef GAME_PAUSE_EN
                else if (pause_btn) begin
                    state_d = PAUSE;
                end
`endif
            end
            LEVEL_UP: begin
                level_d = level_q + VW'(1);
                state_d = PLAY;
            end
            DYING: begin
                if (timer_expire_c) state_d = (lives_q == '0) ? GAME_OVER : REPLAY;
            end
            REPLAY: begin
                state_d = PLAY;
            end
            GAME_OVER: begin
                if (timer_expire_c) state_d = INTRO;
            end
`ifdef GAME_PAUSE_EN
            PAUSE: begin
                if (pause_btn) state_d = PLAY;
            end
`endif
            default: begin
                state_d = INTRO;
            end
        endcase
    end

    // Flag outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= INTRO;
            lives_q     <= LW'(LIVES);
            level_q     <= '0;
            won_q       <= 1'b0;
            isIntro     <= 1'b1;
            restart     <= 1'b0;
            replay      <= 1'b0;
            level_start <= 1'b0;
            dying       <= 1'b0;
            game_over   <= 1'b0;
            paused      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            won_q       <= won_d;
            isIntro     <= (state_d == INTRO);
            restart     <= (state_d == START);
            replay      <= (state_d == REPLAY);
            level_start <= (state_d == LEVEL_UP);
            dying       <= (state_d == DYING);
            game_over   <= (state_d == GAME_OVER);
`ifdef GAME_PAUSE_EN
            paused      <= (state_d == PAUSE);
`else
            paused      <= 1'b0;
`endif
        end
    end

    assign lives = lives_q;
    assign level = level_q;
    assign won   = won_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed vector table, hand sequences,
// and randomized stimulus against a screen/pulse reference model.
module tb_game_flow_ctrl;

    localparam int unsigned LIVES = 3;
    localparam int unsigned LEVELS = 2;
    localparam int unsigned DT = 4;
    localparam int unsigned GT = 3;

    // input bundle {Reset, Execute, finish, fail, frame_tick, pause_btn}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_RST  = 6'b100000;
    localparam logic [5:0] I_EX   = 6'b010000;
    localparam logic [5:0] I_FIN  = 6'b001000;
    localparam logic [5:0] I_FAIL = 6'b000100;
    localparam logic [5:0] I_TK   = 6'b000010;
    localparam logic [5:0] I_PB   = 6'b000001;

    // flag bundle {isIntro, restart, replay, level_start, dying, game_over, won, paused}
    localparam logic [7:0] F_PLAY    = 8'b00000000;
    localparam logic [7:0] F_INTRO   = 8'b10000000;
    localparam logic [7:0] F_RESTART = 8'b01000000;
    localparam logic [7:0] F_REPLAY  = 8'b00100000;
    localparam logic [7:0] F_LVST    = 8'b00010000;
    localparam logic [7:0] F_DYING   = 8'b00001000;
    localparam logic [7:0] F_GO      = 8'b00000100;
    localparam logic [7:0] F_WON     = 8'b00000010;
    localparam logic [7:0] F_PAUSED  = 8'b00000001;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0, Execute = 1'b0, finish = 1'b0, fail = 1'b0;
    logic       frame_tick = 1'b0, pause_btn = 1'b0;
    logic       isIntro, restart, replay, level_start, dying, game_over, won, paused;
    logic [1:0] lives;
    logic [0:0] level;

    int compared = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    game_flow_ctrl #(
        .LIVES          (LIVES),
        .LEVELS         (LEVELS),
        .DEATH_TICKS    (DT),
        .GAMEOVER_TICKS (GT)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Execute     (Execute),
        .finish      (finish),
        .fail        (fail),
        .frame_tick  (frame_tick),
        .pause_btn   (pause_btn),
        .isIntro     (isIntro),
        .restart     (restart),
        .replay      (replay),
        .level_start (level_start),
        .dying       (dying),
        .game_over   (game_over),
        .won         (won),
        .paused      (paused),
        .lives       (lives),
        .level       (level)
    );

    typedef struct packed {
        logic [5:0] in;
        logic [7:0] flags;
        logic [1:0] lv;
        logic [0:0] lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [5:0] in, input logic [7:0] f, input int lv, input int lvl);
        vec_t v;
        v.in    = in;
        v.flags = f;
        v.lv    = 2'(lv);
        v.lvl   = 1'(lvl);
        vecs.push_back(v);
    endfunction

    function automatic logic [10:0] dut_out();
        return {isIntro, restart, replay, level_start, dying, game_over, won, paused, lives, level};
    endfunction

    task automatic apply(input logic [5:0] in);
        @(negedge Clk);
        {Reset, Execute, finish, fail, frame_tick, pause_btn} = in;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got flags=%b lives=%0d level=%0d, expected flags=%b lives=%0d level=%0d",
                     name, act[10:3], act[2:1], act[0], exp[10:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic step_check(input string name, input logic [5:0] in, input logic [7:0] f,
                              input int lv, input int lvl);
        apply(in);
        check(name, dut_out(), {f, 2'(lv), 1'(lvl)});
    endtask

    // ---------------- reference model ----------------
    localparam int SCR_INTRO = 0, SCR_PLAY = 1, SCR_DYING = 2, SCR_OVER = 3, SCR_PAUSE = 4;
    localparam int P_NONE = 0, P_RESTART = 1, P_REPLAY = 2, P_LEVEL = 3;

    int m_scr, m_pulse, m_remain, m_lives, m_level;
    bit m_won;

    function automatic void model_step(input logic [5:0] in);
        bit rst, ex, fin, fl, tk, pb;
        {rst, ex, fin, fl, tk, pb} = in;
        if (rst) begin
            m_scr = SCR_INTRO; m_pulse = P_NONE; m_remain = 0;
            m_lives = LIVES; m_level = 0; m_won = 0;
        end else if (m_pulse != P_NONE) begin
            if (m_pulse == P_RESTART) begin
                m_lives = LIVES; m_level = 0; m_won = 0;
            end else if (m_pulse == P_LEVEL) begin
                m_level++;
            end
            m_pulse = P_NONE;
            m_scr = SCR_PLAY;
        end else begin
            case (m_scr)
                SCR_INTRO: if (ex) begin m_pulse = P_RESTART; m_scr = SCR_PLAY; end
                SCR_PLAY: begin
                    if (fin) begin
                        if (m_level == LEVELS - 1) begin
                            m_scr = SCR_OVER; m_remain = GT; m_won = 1;
                        end else begin
                            m_pulse = P_LEVEL;
                        end
                    end else if (fl) begin
                        m_lives--; m_scr = SCR_DYING; m_remain = DT;
                    end
`ifdef GAME_PAUSE_EN
                    else if (pb) m_scr = SCR_PAUSE;
`endif
                end
                SCR_DYING: if (tk) begin
                    m_remain--;
                    if (m_remain == 0) begin
                        if (m_lives == 0) begin m_scr = SCR_OVER; m_remain = GT; end
                        else m_pulse = P_REPLAY;
                    end
                end
                SCR_OVER: if (tk) begin
                    m_remain--;
                    if (m_remain == 0) m_scr = SCR_INTRO;
                end
                SCR_PAUSE: if (pb) m_scr = SCR_PLAY;
                default: m_scr = SCR_INTRO;
            endcase
        end
    endfunction

    function automatic logic [10:0] model_out();
        bit idle;
        idle = (m_pulse == P_NONE);
        return {idle && m_scr == SCR_INTRO, m_pulse == P_RESTART, m_pulse == P_REPLAY,
                m_pulse == P_LEVEL, idle && m_scr == SCR_DYING, idle && m_scr == SCR_OVER,
                m_won, idle && m_scr == SCR_PAUSE, 2'(m_lives), 1'(m_level)};
    endfunction

    initial begin
        // ---- directed table: game start, death/replay, level up, win, loss, reset mid-hold ----
        add(I_RST, F_INTRO, 3, 0);
        add(I_NONE, F_INTRO, 3, 0);
        add(I_FIN | I_FAIL, F_INTRO, 3, 0);
        add(I_TK, F_INTRO, 3, 0);
        add(I_EX, F_RESTART, 3, 0);
        add(I_NONE, F_PLAY, 3, 0);
        add(I_EX | I_TK, F_PLAY, 3, 0);
        add(I_FAIL, F_DYING, 2, 0);
        add(I_TK, F_DYING, 2, 0);
        add(I_FIN | I_FAIL, F_DYING, 2, 0);
        add(I_TK, F_DYING, 2, 0);
        add(I_TK, F_DYING, 2, 0);
        add(I_TK, F_REPLAY, 2, 0);
        add(I_NONE, F_PLAY, 2, 0);
        add(I_FIN | I_FAIL, F_LVST, 2, 0);
        add(I_NONE, F_PLAY, 2, 1);
        add(I_FIN, F_GO | F_WON, 2, 1);
        add(I_EX, F_GO | F_WON, 2, 1);
        add(I_TK, F_GO | F_WON, 2, 1);
        add(I_TK, F_GO | F_WON, 2, 1);
        add(I_TK, F_INTRO | F_WON, 2, 1);
        add(I_NONE, F_INTRO | F_WON, 2, 1);
        add(I_EX, F_RESTART | F_WON, 2, 1);
        add(I_NONE, F_PLAY, 3, 0);
        for (int d = 2; d >= 0; d--) begin
            add(I_FAIL, F_DYING, d, 0);
            for (int k = 0; k < 3; k++) add(I_TK, F_DYING, d, 0);
            if (d > 0) begin
                add(I_TK, F_REPLAY, d, 0);
                add(I_NONE, F_PLAY, d, 0);
            end else begin
                add(I_TK, F_GO, 0, 0);
            end
        end
        add(I_TK, F_GO, 0, 0);
        add(I_TK, F_GO, 0, 0);
        add(I_TK, F_INTRO, 0, 0);
        add(I_EX, F_RESTART, 0, 0);
        add(I_NONE, F_PLAY, 3, 0);
        add(I_FAIL, F_DYING, 2, 0);
        add(I_TK, F_DYING, 2, 0);
        add(I_RST | I_TK, F_INTRO, 3, 0);

        foreach (vecs[i]) begin
            step_check($sformatf("vec%0d", i), vecs[i].in, vecs[i].flags, vecs[i].lv, vecs[i].lvl);
        end

        // ---- reset during GAME_OVER drops won and restores counters ----
        step_check("go_rst_start", I_EX, F_RESTART, 3, 0);
        step_check("go_rst_play", I_NONE, F_PLAY, 3, 0);
        step_check("go_rst_lvup", I_FIN, F_LVST, 3, 0);
        step_check("go_rst_play1", I_NONE, F_PLAY, 3, 1);
        step_check("go_rst_win", I_FIN, F_GO | F_WON, 3, 1);
        step_check("go_rst_tick", I_TK, F_GO | F_WON, 3, 1);
        step_check("go_rst_reset", I_RST | I_TK, F_INTRO, 3, 0);

        // ---- pause handling ----
        step_check("pz_start", I_EX, F_RESTART, 3, 0);
        step_check("pz_play", I_NONE, F_PLAY, 3, 0);
`ifdef GAME_PAUSE_EN
        step_check("pz_enter", I_PB, F_PAUSED, 3, 0);
        step_check("pz_ignore", I_FIN | I_FAIL | I_TK | I_EX, F_PAUSED, 3, 0);
        step_check("pz_leave", I_PB, F_PLAY, 3, 0);
        step_check("pz_fail_wins", I_FAIL | I_PB, F_DYING, 2, 0);
`else
        step_check("pz_ignored", I_PB, F_PLAY, 3, 0);
        step_check("pz_fail", I_FAIL | I_PB, F_DYING, 2, 0);
`endif

        // ---- randomized run against the reference model ----
        apply(I_RST);
        model_step(I_RST);
        check("rnd_reset", dut_out(), model_out());
        for (int c = 0; c < 4000; c++) begin
            logic [5:0] in;
            in[5] = ($urandom_range(0, 299) == 0);
            in[4] = ($urandom_range(0, 3) == 0);
            in[3] = ($urandom_range(0, 11) == 0);
            in[2] = ($urandom_range(0, 7) == 0);
            in[1] = ($urandom_range(0, 1) == 0);
            in[0] = ($urandom_range(0, 7) == 0);
            apply(in);
            model_step(in);
            check($sformatf("rnd%0d", c), dut_out(), model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Parametrised top-level game-flow sequencer: intro screen, game start, per-life replay, level advance, death animation hold and game-over hold.
- Sits between the input/keycode logic (Execute), the maze/collision logic (finish, fail) and the sprite/renderer resets (restart, replay, level_start).
- Owns the lives and level counters the HUD displays.

Parameters:
- LIVES, 3, lives per game; must be >= 1.
- LEVELS, 4, levels per game; must be >= 1; the last level is LEVELS-1.
- DEATH_TICKS, 60, frame_tick pulses held in DYING; must be >= 1.
- GAMEOVER_TICKS, 120, frame_tick pulses held in GAME_OVER; must be >= 1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Execute  in  1  start request; used only in INTRO.
- finish  in  1  level-cleared pulse; used only in PLAY.
- fail  in  1  player-caught pulse; used only in PLAY.
- frame_tick  in  1  one-cycle pulse per video frame; advances the hold timer.
- pause_btn  in  1  one-cycle pause toggle; ignored unless GAME_PAUSE_EN is defined.
- isIntro  out  1  state is INTRO.
- restart  out  1  one-cycle full-game reset pulse (START).
- replay  out  1  one-cycle reposition pulse after a death (REPLAY).
- level_start  out  1  one-cycle new-level pulse (LEVEL_UP).
- dying  out  1  state is DYING.
- game_over  out  1  state is GAME_OVER.
- won  out  1  last game ended by clearing level LEVELS-1.
- paused  out  1  state is PAUSE; tied to 0 without GAME_PAUSE_EN.
- lives  out  LW=$clog2(LIVES+1)  remaining lives.
- level  out  VW=max(1,$clog2(LEVELS))  current level index.

Behaviour:
- Reset (priority over everything, including mid-DYING/GAME_OVER):
  - state=INTRO, lives=LIVES, level=0, won=0, timer=0.
  - Outputs: isIntro=1, all others 0.
- Output decoding:
  - All single-bit outputs are Moore, decoded from the registered state.
  - lives, level and won are registers.
- Transitions; each is one clock unless stated:
  - INTRO: Execute=1 -> START. Otherwise stay.
  - START: restart=1; load lives=LIVES, level=0, won=0 -> PLAY.
  - PLAY: finish has priority over fail when both are 1 in the same cycle.
    - finish with level==LEVELS-1 -> GAME_OVER, won<=1.
    - finish otherwise -> LEVEL_UP.
    - fail -> DYING, lives<=lives-1.
  - LEVEL_UP: level_start=1, level<=level+1 -> PLAY.
  - DYING: dying=1.
    - Each frame_tick increments the timer.
    - When frame_tick=1 and timer==DEATH_TICKS-1: lives==0 -> GAME_OVER, else -> REPLAY.
  - REPLAY: replay=1 -> PLAY. lives and level unchanged.
  - GAME_OVER: game_over=1.
    - When frame_tick=1 and timer==GAMEOVER_TICKS-1 -> INTRO.
    - Execute is ignored here.
- Timer:
  - Cleared on every state change.
  - Counts only frame_tick pulses.
  - Width $clog2(max(DEATH_TICKS,GAMEOVER_TICKS)+1).
- Boundary cases:
  - fail or finish outside PLAY: ignored.
  - Execute outside INTRO: ignored.
  - LIVES=1: the first fail leads to GAME_OVER.
  - LEVELS=1: the first finish leads to GAME_OVER with won=1.
  - lives never underflows, because DYING is entered only with lives>=1.
  - won holds through INTRO until the next START or Reset.
- No illegal-state lockup: the default branch returns to INTRO.

Optional Feature:
- GAME_PAUSE_EN defined:
  - Adds a PAUSE state and makes paused=1 while in it.
  - pause_btn=1 in PLAY -> PAUSE; pause_btn=1 in PAUSE -> PLAY.
  - fail, finish and frame_tick are ignored in PAUSE. The timer is not running there (PLAY has no timer).
  - Simultaneous events in PLAY: finish > fail > pause_btn.
- GAME_PAUSE_EN undefined: no PAUSE state, pause_btn unused, paused=0.

Decomposition:
- game_flow_pkg holds:
  - the state enum typedef (INTRO, START, PLAY, LEVEL_UP, DYING, REPLAY, GAME_OVER, PAUSE);
  - the width helper functions for LW and VW.
- Sub-module tick_timer:
  - Inputs clear and tick; parameter MAX; output expire on the terminal tick.
  - Instantiated once, with the terminal count muxed by state.

Test Plan (LIVES=3, LEVELS=2, DEATH_TICKS=4, GAMEOVER_TICKS=3):
1. Reset, then Execute pulse -> isIntro falls, restart=1 for exactly 1 cycle, then PLAY with lives=3, level=0.
2. fail in PLAY -> dying=1, lives=2; 4 frame_ticks -> replay=1 for 1 cycle, then PLAY, level=0.
3. finish and fail in the same cycle at level 0 -> level_start=1 for 1 cycle, level=1, lives unchanged.
4. finish at level 1 -> game_over=1, won=1; 3 frame_ticks -> INTRO, won still 1; Execute -> START clears won.
5. Three fails with 4 ticks each -> the third DYING exits to GAME_OVER with lives=0, won=0; Reset during the second tick of DYING -> INTRO, lives=3.
6. GAME_PAUSE_EN: pause_btn in PLAY -> paused=1; fail and finish ignored while paused; pause_btn -> PLAY with lives and level intact.
